// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 iterative MUL/UMULL/SMULL/UDIV/SDIV sequencer with pipeline stall.
// Define MULDIV_SIGNED_EN to enable SMULL/SDIV sign handling; otherwise they run unsigned.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flags
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] acc, add_s, sh_r;
  logic [WIDTH-1:0] mq, md, a_mag, b_mag, q_f, r_f, lo_n, hi_n;
  logic [2*WIDTH-1:0] p_f;
  logic div_r, long_r, is_div, is_long, ge, dz;
  logic [2:0] flags_n;
  assign is_div  = op == 3'b001 || op == 3'b011;
  assign is_long = op == 3'b100 || op == 3'b110;
`ifdef MULDIV_SIGNED_EN
  logic sa, sb, a_neg, b_neg;
  assign a_neg = (op == 3'b110 || op == 3'b011) & a[WIDTH-1];
  assign b_neg = (op == 3'b110 || op == 3'b011) & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign p_f   = (sa ^ sb) ? -{acc[WIDTH-1:0], mq} : {acc[WIDTH-1:0], mq};
  assign q_f   = (sa ^ sb) ? -mq : mq;
  assign r_f   = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`else
  assign a_mag = a;
  assign b_mag = b;
  assign p_f   = {acc[WIDTH-1:0], mq};
  assign q_f   = mq;
  assign r_f   = acc[WIDTH-1:0];
`endif
  assign add_s = acc + (mq[0] ? {1'b0, md} : '0);
  assign sh_r  = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign ge    = sh_r >= {1'b0, md};
  // A zero divisor leaves the raw dividend in mq so it can be returned as the remainder.
  assign dz      = div_r && md == '0;
  assign lo_n    = dz ? '1 : div_r ? q_f : p_f[WIDTH-1:0];
  assign hi_n    = dz ? mq : div_r ? r_f : p_f[2*WIDTH-1:WIDTH];
  assign flags_n = {long_r ? hi_n[WIDTH-1] : lo_n[WIDTH-1],
                    long_r ? {hi_n, lo_n} == '0 : lo_n == '0, dz};
  assign busy  = state != IDLE;
  assign stall = busy | (start & ~done);
  always_comb begin
    state_n = state == IDLE ? (start ? ((is_div && b == '0) ? FIX : RUN) : IDLE)
            : state == RUN  ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      mq        <= '0;
      md        <= '0;
      div_r     <= 1'b0;
      long_r    <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
`ifdef MULDIV_SIGNED_EN
      sa        <= 1'b0;
      sb        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        div_r  <= is_div;
        long_r <= is_long;
        cnt    <= CW'(WIDTH);
        acc    <= '0;
        md     <= b_mag;
        mq     <= (is_div && b == '0) ? a : a_mag;
`ifdef MULDIV_SIGNED_EN
        sa     <= a_neg;
        sb     <= b_neg;
`endif
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
        acc <= div_r ? (ge ? sh_r - {1'b0, md} : sh_r) : {1'b0, add_s[WIDTH:1]};
        mq  <= div_r ? {mq[WIDTH-2:0], ge} : {add_s[0], mq[WIDTH-1:1]};
      end else if (state == FIX) begin
        done      <= 1'b1;
        result_lo <= lo_n;
        result_hi <= hi_n;
        flags     <= flags_n;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, stall, done;
  logic [31:0] result_lo, result_hi;
  logic [2:0] flags;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [2:0] f;
    logic [2:0] m;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done lo=%h hi=%h", result_lo, result_hi);
      end else begin
        e = exp_q.pop_front();
        if (result_lo !== e.lo || result_hi !== e.hi || (flags & e.m) !== (e.f & e.m)) begin
          errors++;
          $display("FAIL result got lo=%h hi=%h flags=%b expected lo=%h hi=%h flags=%b mask=%b",
                   result_lo, result_hi, flags, e.lo, e.hi, e.f, e.m);
        end
      end
    end
  end
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] el, input logic [31:0] eh,
                        input logic [2:0] ef, input logic [2:0] fm, input int lat);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back('{el, eh, ef, fm});
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_request got %b want 1", stall); end
    @(posedge clk);
    @(negedge clk);
    n = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b want 1", busy); end
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != lat) begin
      errors++; $display("FAIL latency op=%b got %0d want %0d", o, n, lat);
    end
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_cycle stall=%b busy=%b want 0 0", stall, busy);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({busy, stall, done, result_lo, result_hi, flags} !== '0) begin
      errors++; $display("FAIL reset_state busy=%b stall=%b done=%b lo=%h hi=%h flags=%b want all 0",
                         busy, stall, done, result_lo, result_hi, flags);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_mul;
    run_op(3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 3'b000, 3'b111, 34);
    run_op(3'b000, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h0, 3'b100, 3'b111, 34);
    run_op(3'b111, 32'h6, 32'h7, 32'd42, 32'h0, 3'b000, 3'b111, 34);
  endtask
  task automatic test_long;
    run_op(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 3'b100, 3'b111, 34);
`ifdef MULDIV_SIGNED_EN
    run_op(3'b110, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 3'b100, 3'b111, 34);
`else
    run_op(3'b110, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'd2, 3'b000, 3'b111, 34);
`endif
  endtask
  task automatic test_div;
    run_op(3'b001, 32'd100, 32'd7, 32'd14, 32'd2, 3'b000, 3'b111, 34);
`ifdef MULDIV_SIGNED_EN
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b100, 3'b111, 34);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 3'b000, 3'b001, 34);
`else
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h1, 3'b000, 3'b111, 34);
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 3'b010, 3'b111, 34);
`endif
  endtask
  task automatic test_divzero;
    run_op(3'b001, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 3'b001, 3'b001, 2);
    run_op(3'b000, 32'h0, 32'h5, 32'h0, 32'h0, 3'b010, 3'b111, 34);
  endtask
  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'd6; start = 1'b1;
    exp_q.push_back('{32'd42, 32'h0, 3'b000, 3'b111});
    @(posedge clk);
    @(negedge clk);
    op = 3'b100; a = 32'd3; b = 32'd5;
    exp_q.push_back('{32'd15, 32'h0, 3'b000, 3'b111});
    n = 1;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != 34) begin errors++; $display("FAIL b2b_first_latency got %0d want 34", n); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_first_stall got %b want 0", stall); end
    @(negedge clk);
    n = 1;
    checks++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept busy=%b stall=%b want 1 1", busy, stall);
    end
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1 || n != 34) begin errors++; $display("FAIL b2b_second_latency got %0d want 34", n); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_second_stall got %b want 0", stall); end
    start = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    op = 3'b001; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, stall, done, result_lo, result_hi, flags} !== '0) begin
      errors++; $display("FAIL reset_mid busy=%b stall=%b done=%b lo=%h hi=%h flags=%b want all 0",
                         busy, stall, done, result_lo, result_hi, flags);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run_op(3'b001, 32'd100, 32'd7, 32'd14, 32'd2, 3'b000, 3'b111, 34);
  endtask
  initial begin
    test_reset();
    test_mul();
    test_long();
    test_div();
    test_divzero();
    test_back_to_back();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL missing_results got %0d pending want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
